// File: rtl/lcd_sequencer_if.sv
// rtl/lcd_sequencer_if.sv - Control, status and LCD handshake bundle for lcd_sequencer.
// master modport is the sequencer side; slave is the host/LCD side.
interface lcd_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  repeat_en;
  logic                  lcd_busy;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic                  data_ready;
  logic                  active;
  logic                  done;
  logic                  error;
  logic [CNT_WIDTH-1:0]  char_count;

  modport master (
    input  start, abort, start_addr, last_addr, repeat_en, lcd_busy,
    output rom_address, data_ready, active, done, error, char_count
  );

  modport slave (
    output start, abort, start_addr, last_addr, repeat_en, lcd_busy,
    input  rom_address, data_ready, active, done, error, char_count
  );
endinterface

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - ROM-to-LCD character sequencer with range, abort, status and busy timeout.
// Loop mode is built only when LCD_SEQ_REPEAT_EN is defined.
module lcd_sequencer #(
  parameter int ADDR_WIDTH   = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic            clock,
  input  logic            internal_reset_n,
  lcd_sequencer_if.master bus
);

  localparam int              TO_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
  localparam bit              TO_EN   = (BUSY_TIMEOUT > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PRESENT,
    S_WAIT_FREE,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_end_q;
  logic [ADDR_WIDTH-1:0] w_end_q_nxt;
  logic                  r_data_ready;
  logic                  w_data_ready_nxt;
  logic                  r_active;
  logic                  w_active_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_error;
  logic                  w_error_nxt;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  w_count_nxt;
  logic [TO_W-1:0]       r_to_cnt;
  logic [TO_W-1:0]       w_to_cnt_nxt;

`ifdef LCD_SEQ_REPEAT_EN
  logic [ADDR_WIDTH-1:0] r_start_q;
  logic [ADDR_WIDTH-1:0] w_start_q_nxt;
`else
  logic                  w_unused_repeat_en;
  assign w_unused_repeat_en = bus.repeat_en;
`endif

  always_ff @(posedge clock or negedge internal_reset_n) begin
    if (!internal_reset_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_end_q      <= '0;
      r_data_ready <= 1'b0;
      r_active     <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_count      <= '0;
      r_to_cnt     <= '0;
`ifdef LCD_SEQ_REPEAT_EN
      r_start_q    <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_end_q      <= w_end_q_nxt;
      r_data_ready <= w_data_ready_nxt;
      r_active     <= w_active_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
      r_count      <= w_count_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
`ifdef LCD_SEQ_REPEAT_EN
      r_start_q    <= w_start_q_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_end_q_nxt      = r_end_q;
    w_data_ready_nxt = r_data_ready;
    w_active_nxt     = r_active;
    w_done_nxt       = r_done;
    w_error_nxt      = r_error;
    w_count_nxt      = r_count;
    w_to_cnt_nxt     = r_to_cnt;
`ifdef LCD_SEQ_REPEAT_EN
    w_start_q_nxt    = r_start_q;
`endif

    // abort outranks everything, including a start in the same cycle
    if (bus.abort) begin
      w_state_nxt      = S_IDLE;
      w_data_ready_nxt = 1'b0;
      w_active_nxt     = 1'b0;
      w_done_nxt       = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.start_addr <= bus.last_addr) begin
              w_end_q_nxt  = bus.last_addr;
              w_addr_nxt   = bus.start_addr;
              w_active_nxt = 1'b1;
              w_done_nxt   = 1'b0;
              w_error_nxt  = 1'b0;
              w_count_nxt  = '0;
              w_state_nxt  = S_ARM;
`ifdef LCD_SEQ_REPEAT_EN
              w_start_q_nxt = bus.start_addr;
`endif
            end else begin
              w_error_nxt = 1'b1;
              w_done_nxt  = 1'b0;
            end
          end
        end

        S_ARM: begin
          if (!bus.lcd_busy) begin
            w_data_ready_nxt = 1'b1;
            w_to_cnt_nxt     = '0;
            w_state_nxt      = S_PRESENT;
          end
        end

        S_PRESENT: begin
          if (bus.lcd_busy) begin
            w_data_ready_nxt = 1'b0;
            w_count_nxt      = r_count + CNT_WIDTH'(1);
            // end check before increment keeps the address from wrapping
            if (r_addr == r_end_q) begin
`ifdef LCD_SEQ_REPEAT_EN
              if (bus.repeat_en) begin
                w_addr_nxt  = r_start_q;
                w_state_nxt = S_WAIT_FREE;
              end else begin
                w_state_nxt = S_DRAIN;
              end
`else
              w_state_nxt = S_DRAIN;
`endif
            end else begin
              w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
              w_state_nxt = S_WAIT_FREE;
            end
          end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
            w_data_ready_nxt = 1'b0;
            w_active_nxt     = 1'b0;
            w_error_nxt      = 1'b1;
            w_state_nxt      = S_IDLE;
          end else begin
            w_to_cnt_nxt = r_to_cnt + TO_W'(1);
          end
        end

        S_WAIT_FREE: begin
          if (!bus.lcd_busy) begin
            w_data_ready_nxt = 1'b1;
            w_to_cnt_nxt     = '0;
            w_state_nxt      = S_PRESENT;
          end
        end

        S_DRAIN: begin
          if (!bus.lcd_busy) begin
            w_active_nxt = 1'b0;
            w_done_nxt   = 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.rom_address = r_addr;
  assign bus.data_ready  = r_data_ready;
  assign bus.active      = r_active;
  assign bus.done        = r_done;
  assign bus.error       = r_error;
  assign bus.char_count  = r_count;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - Scoreboard bench for lcd_sequencer with a 5-cycle-busy LCD model.
// Loop-mode scenario is included when LCD_SEQ_REPEAT_EN is defined.
module tb_lcd_sequencer;
  localparam int AW = 4;
  localparam int CW = 16;
  localparam int TO = 8;

  logic          clock = 1'b0;
  logic          internal_reset_n;
  logic          lcd_force;
  logic          lcd_auto;
  logic          model_busy = 1'b0;
  int            busy_cnt   = 0;
  int            n_cmp      = 0;
  int            n_err      = 0;
  logic [AW-1:0] sb[$];

  lcd_sequencer_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  lcd_sequencer #(
    .ADDR_WIDTH   (AW),
    .CNT_WIDTH    (CW),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clock            (clock),
    .internal_reset_n (internal_reset_n),
    .bus              (bus)
  );

  always #5 clock = ~clock;

  assign bus.lcd_busy = lcd_force | model_busy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // LCD model: takes a presented word, stays busy 5 cycles, scoreboard checks the address
  always @(negedge clock) begin
    if (busy_cnt != 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end else if (lcd_auto && bus.data_ready && !model_busy) begin
      model_busy = 1'b1;
      busy_cnt   = 5;
      check_eq("sb_pending", sb.size() != 0, 1);
      if (sb.size() != 0) check_eq("word_addr", bus.rom_address, sb.pop_front());
    end
  end

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] l, input bit push);
    @(negedge clock);
    bus.start      = 1'b1;
    bus.start_addr = s;
    bus.last_addr  = l;
    if (push) for (int a = int'(s); a <= int'(l); a++) sb.push_back(AW'(a));
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.active && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_eq(tag, bus.active, 0);
  endtask

  initial begin
    int n;
    int dr_cycles;
    logic dr_seen;

    internal_reset_n = 1'b0;
    lcd_force        = 1'b1;
    lcd_auto         = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.start_addr   = '0;
    bus.last_addr    = '0;
    bus.repeat_en    = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_addr",   bus.rom_address, 0);
    check_eq("rst_dr",     bus.data_ready, 0);
    check_eq("rst_active", bus.active, 0);
    check_eq("rst_done",   bus.done, 0);
    check_eq("rst_error",  bus.error, 0);
    check_eq("rst_count",  bus.char_count, 0);
    internal_reset_n = 1'b1;

    // T1: full range while the LCD is still busy from power-up
    do_start(4'd0, 4'd15, 1'b1);
    check_eq("t1_active", bus.active, 1);
    check_eq("t1_arm_dr", bus.data_ready, 0);
    repeat (17) @(negedge clock);
    check_eq("t1_arm_hold", bus.data_ready, 0);
    lcd_force = 1'b0;
    wait_idle(400, "t1_finish");
    check_eq("t1_done",  bus.done, 1);
    check_eq("t1_count", bus.char_count, 16);
    check_eq("t1_error", bus.error, 0);
    check_eq("t1_addr",  bus.rom_address, 15);
    check_eq("t1_sb",    sb.size(), 0);

    // T2: inverted range
    do_start(4'd9, 4'd3, 1'b0);
    check_eq("t2_error",  bus.error, 1);
    check_eq("t2_active", bus.active, 0);
    check_eq("t2_done",   bus.done, 0);
    check_eq("t2_addr",   bus.rom_address, 15);
    dr_seen = bus.data_ready;
    repeat (5) begin
      @(negedge clock);
      dr_seen = dr_seen | bus.data_ready;
    end
    check_eq("t2_no_dr", dr_seen, 0);

    // T3: LCD never acknowledges
    while (busy_cnt != 0) @(negedge clock);
    lcd_auto = 1'b0;
    do_start(4'd2, 4'd6, 1'b0);
    check_eq("t3_err_clr", bus.error, 0);
    check_eq("t3_active",  bus.active, 1);
    n = 0;
    dr_cycles = 0;
    while (bus.active && n < 50) begin
      @(negedge clock);
      n++;
      if (bus.data_ready) dr_cycles++;
    end
    check_eq("t3_finish", bus.active, 0);
    check_eq("t3_dr_cycles", dr_cycles, TO);
    check_eq("t3_error", bus.error, 1);
    check_eq("t3_addr",  bus.rom_address, 2);
    check_eq("t3_dr",    bus.data_ready, 0);
    check_eq("t3_count", bus.char_count, 0);

    // T4: abort together with start while the third word is presented
    lcd_auto = 1'b1;
    sb.push_back(4'd0);
    sb.push_back(4'd1);
    sb.push_back(4'd2);
    do_start(4'd0, 4'd7, 1'b0);
    n = 0;
    while (!(bus.data_ready && bus.rom_address == 4'd2) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_eq("t4_word3", bus.data_ready && bus.rom_address == 4'd2, 1);
    bus.abort      = 1'b1;
    bus.start      = 1'b1;
    bus.start_addr = 4'd5;
    bus.last_addr  = 4'd6;
    @(negedge clock);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check_eq("t4_active", bus.active, 0);
    check_eq("t4_dr",     bus.data_ready, 0);
    check_eq("t4_done",   bus.done, 0);
    check_eq("t4_count",  bus.char_count, 2);
    check_eq("t4_addr",   bus.rom_address, 2);
    check_eq("t4_error",  bus.error, 0);
    check_eq("t4_sb",     sb.size(), 0);
    do_start(4'd4, 4'd4, 1'b1);
    wait_idle(100, "t4_single_finish");
    check_eq("t4_single_done",  bus.done, 1);
    check_eq("t4_single_count", bus.char_count, 1);
    check_eq("t4_single_addr",  bus.rom_address, 4);

    // T5: single word at the top of the address space
    do_start(4'd15, 4'd15, 1'b1);
    wait_idle(100, "t5_finish");
    check_eq("t5_done",  bus.done, 1);
    check_eq("t5_count", bus.char_count, 1);
    repeat (5) @(negedge clock);
    check_eq("t5_addr", bus.rom_address, 15);
    check_eq("t5_dr",   bus.data_ready, 0);
    check_eq("t5_sb",   sb.size(), 0);

`ifdef LCD_SEQ_REPEAT_EN
    // T6: loop 1..3 twice, then release the loop
    for (int p = 0; p < 2; p++) for (int a = 1; a <= 3; a++) sb.push_back(AW'(a));
    bus.repeat_en = 1'b1;
    do_start(4'd1, 4'd3, 1'b0);
    n = 0;
    while (bus.char_count != 16'd4 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_eq("t6_count4",   bus.char_count, 4);
    check_eq("t6_looping",  bus.active, 1);
    check_eq("t6_no_done",  bus.done, 0);
    bus.repeat_en = 1'b0;
    wait_idle(200, "t6_finish");
    check_eq("t6_done",  bus.done, 1);
    check_eq("t6_count", bus.char_count, 6);
    check_eq("t6_addr",  bus.rom_address, 3);
    check_eq("t6_sb",    sb.size(), 0);
`endif

    // T7: asynchronous reset in the middle of a run
    do_start(4'd0, 4'd15, 1'b1);
    n = 0;
    while (bus.char_count != 16'd3 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_eq("t7_count3", bus.char_count, 3);
    #2 internal_reset_n = 1'b0;
    #1;
    check_eq("t7_addr",   bus.rom_address, 0);
    check_eq("t7_dr",     bus.data_ready, 0);
    check_eq("t7_active", bus.active, 0);
    check_eq("t7_done",   bus.done, 0);
    check_eq("t7_error",  bus.error, 0);
    check_eq("t7_count",  bus.char_count, 0);
    sb.delete();
    @(negedge clock);
    internal_reset_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
